dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0) and a secondary master (port 1), such as a debug/loader or DMA engine.
- Port 0 has fixed priority. A starvation counter forces a port-1 grant after a bounded wait.
- Drives the memory's address, write-data, read-enable and write-enable. Captures combinational read data into a registered response per port.
- Sits between the pipeline/secondary master and the data memory; the memory itself is unchanged.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 has fixed priority, port 1 is forced
// ahead after STARVE_MAX consecutive denied cycles. Read data is registered per port.

module dmem_arbiter_rsp #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= cap;
      if (cap) rdata <= mem_rdata;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starved
);
  localparam int NUM_PORTS = 2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  dmem_req_t [NUM_PORTS-1:0]             req_s;
  logic      [NUM_PORTS-1:0]             gnt, cap, rvalid_v;
  logic      [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;
  logic      [3:0]                       starve_cnt;

  assign req_s[0] = '{we: we0, addr: addr0, wdata: wdata0};
  assign req_s[1] = '{we: we1, addr: addr1, wdata: wdata1};

  // Grants are gated by reset so nothing reaches memory while reset is held.
  assign starved = reset & req1 & (starve_cnt >= STARVE_LIM);
  assign gnt[1]  = reset & req1 & (~req0 | starved);
  assign gnt[0]  = reset & req0 & ~gnt[1];
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        mem_addr  = req_s[p].addr;
        mem_wdata = req_s[p].wdata;
        mem_read  = ~req_s[p].we;
        mem_write = req_s[p].we;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  starve_cnt <= '0;
    else if (!req1 || gnt[1])    starve_cnt <= '0;
    else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      assign cap[gp] = gnt[gp] & ~req_s[gp].we;
      dmem_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
        .clk       (clk),
        .reset     (reset),
        .cap       (cap[gp]),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid_v[gp]),
        .rdata     (rdata_v[gp])
      );
    end
  endgenerate

  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];
  assign rdata0  = rdata_v[0];
  assign rdata1  = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed arbitration checks plus a per-port read
// scoreboard fed at request time and drained whenever rvalid is seen.

module tb_dmem_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write, starved;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] q0[$], q1[$];
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .starved(starved)
  );

  // Behavioural single-port memory: combinational read, write at the edge.
  assign mem_rdata = mem_read ? mem[mem_addr] : '0;
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
      else                chk("rdata0", rdata0, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
      else                chk("rdata1", rdata1, q1.pop_front());
    end
  end

  task automatic p0(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic p1(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  // Advance to just after the next rising edge (drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle point for combinational checks, well before the next edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    mem[1] = 32'h11; mem[2] = 32'h9; mem[3] = 32'h33; mem[7] = 32'hA5;
    reset = 1'b0;
    p0(1'b1, 1'b1, 11'd5, 32'h55);
    p1(1'b0, 1'b0, '0, '0);

    // Reset held with a pending write
    cyc(); cyc(); settle();
    chk("rst_mem_write", mem_write, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_starved", starved, 0);

    cyc(); reset = 1'b1; settle();
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_mem_write", mem_write, 1);
    chk("post_rst_mem_addr", mem_addr, 11'd5);
    chk("post_rst_mem_wdata", mem_wdata, 32'h55);

    // Port-0 read of word 2
    cyc(); p0(1'b1, 1'b0, 11'd2, '0); settle();
    chk("rd0_gnt0", gnt0, 1);
    chk("rd0_mem_read", mem_read, 1);
    chk("rd0_mem_write", mem_write, 0);
    q0.push_back(32'h9);
    cyc(); p0(1'b0, 1'b0, '0, '0); settle();
    chk("rd0_rvalid_n1", rvalid0, 1);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_read", mem_read, 0);
    cyc(); settle();
    chk("rd0_rvalid_n2", rvalid0, 0);
    chk("rd0_rdata_hold", rdata0, 32'h9);

    // Port-1 write then read back
    p1(1'b1, 1'b1, 11'h40, 32'hDEADBEEF); settle();
    chk("wr1_gnt1", gnt1, 1);
    chk("wr1_gnt0", gnt0, 0);
    chk("wr1_mem_write", mem_write, 1);
    chk("wr1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cyc(); p1(1'b1, 1'b0, 11'h40, '0); settle();
    chk("wr1_no_rvalid", rvalid1, 0);
    chk("rd1_gnt1", gnt1, 1);
    chk("rd1_mem_read", mem_read, 1);
    q1.push_back(32'hDEADBEEF);
    cyc(); p1(1'b0, 1'b0, '0, '0); settle();
    chk("rd1_rvalid", rvalid1, 1);

    // Priority then starvation: port 0 holds a read stream, port 1 waits
    cyc();
    p0(1'b1, 1'b0, 11'd3, '0);
    p1(1'b1, 1'b0, 11'h40, '0);
    for (int c = 1; c <= 4; c++) begin
      settle();
      chk($sformatf("stv_c%0d_gnt0", c), gnt0, 1);
      chk($sformatf("stv_c%0d_gnt1", c), gnt1, 0);
      chk($sformatf("stv_c%0d_starved", c), starved, 0);
      q0.push_back(32'h33);
      cyc();
    end
    settle();
    chk("stv_c5_starved", starved, 1);
    chk("stv_c5_gnt1", gnt1, 1);
    chk("stv_c5_gnt0", gnt0, 0);
    chk("stv_c5_mem_addr", mem_addr, 11'h40);
    q1.push_back(32'hDEADBEEF);
    cyc(); settle();
    chk("stv_c6_gnt0", gnt0, 1);
    chk("stv_c6_gnt1", gnt1, 0);
    chk("stv_c6_starved", starved, 0);
    q0.push_back(32'h33);
    cyc(); p0(1'b0, 1'b0, '0, '0); settle();
    chk("stv_c7_gnt1", gnt1, 1);
    q1.push_back(32'hDEADBEEF);
    cyc(); p1(1'b0, 1'b0, '0, '0);

    // Back-to-back reads 1, 2, 3, then the word written after reset
    for (int a = 1; a <= 4; a++) begin
      p0(1'b1, 1'b0, (a == 4) ? 11'd5 : ADDR_W'(a), '0); settle();
      chk($sformatf("b2b_a%0d_gnt0", a), gnt0, 1);
      q0.push_back((a == 1) ? 32'h11 : (a == 2) ? 32'h9 : (a == 3) ? 32'h33 : 32'h55);
      cyc();
      if (a > 1) chk($sformatf("b2b_a%0d_rvalid0", a), rvalid0, 1);
    end
    p0(1'b0, 1'b0, '0, '0);
    cyc();

    // Reset mid-transaction: read response pending, write abandoned
    p0(1'b1, 1'b0, 11'd1, '0);
    cyc();
    reset = 1'b0;
    p0(1'b1, 1'b1, 11'd7, 32'h77); settle();
    chk("midrst_rvalid0", rvalid0, 0);
    chk("midrst_rdata0", rdata0, 0);
    chk("midrst_gnt0", gnt0, 0);
    chk("midrst_mem_write", mem_write, 0);
    cyc(); reset = 1'b1;
    p0(1'b1, 1'b0, 11'd7, '0); settle();
    chk("midrst_rd_gnt0", gnt0, 1);
    q0.push_back(32'hA5);
    cyc(); p0(1'b0, 1'b0, '0, '0);
    cyc(); cyc();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
